// File: rtl/pattern_counter_stream.sv
// pattern_counter_stream: counts a programmable pattern in fixed-length
// serial frames and publishes a saturating count once per frame.
module pattern_counter_stream #(
   parameter int FRAME_LEN = 20,
   parameter int PAT_LEN   = 4,
   parameter int CNT_W     = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic               overlap_en,
   input  logic               bit_in,
   input  logic               bit_valid,
   input  logic               frame_clr,
   output logic               hit,
   output logic [CNT_W-1:0]   count,
   output logic               count_valid,
   output logic               busy
);
   localparam int IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam int SW = $clog2(PAT_LEN);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
   localparam logic [IW-1:0] FILL_END = IW'(PAT_LEN - 2);
   localparam logic [SW-1:0] SKIP_LD = SW'(PAT_LEN - 1);

   typedef enum logic [1:0] {IDLE, FILL, SCAN} state_t;
   state_t state, state_nx;

   logic [IW-1:0]      bit_idx;
   logic [CNT_W-1:0]   acc;
   logic [CNT_W-1:0]   acc_inc;
   logic [SW-1:0]      skip;
   logic [PAT_LEN-2:0] sr;
   logic [PAT_LEN-1:0] pat_q;
   logic [PAT_LEN-1:0] window;
   logic               ovl_q;
   logic               accept;
   logic               last;
   logic               counted;

   assign accept  = bit_valid & ~frame_clr;
   assign window  = {sr, bit_in};
   assign last    = (bit_idx == LAST_IDX);
   assign acc_inc = (acc == CMAX) ? acc : acc + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (frame_clr) begin
         state_nx = IDLE;
      end else if (accept) begin
         unique case (state)
            IDLE:    state_nx = (PAT_LEN == 2) ? SCAN : FILL;
            FILL:    if (bit_idx == FILL_END) state_nx = SCAN;
            SCAN:    if (last) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Non-overlap mode suppresses matches while skip drains.
   always_comb begin
      busy    = (state != IDLE);
      counted = 1'b0;
      if (accept && state == SCAN && window == pat_q)
         counted = ovl_q || (skip == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_idx     <= '0;
         acc         <= '0;
         skip        <= '0;
         sr          <= '0;
         pat_q       <= '0;
         ovl_q       <= 1'b0;
         hit         <= 1'b0;
         count       <= '0;
         count_valid <= 1'b0;
      end else begin
         hit         <= counted;
         count_valid <= 1'b0;
         if (frame_clr) begin
            bit_idx <= '0;
            acc     <= '0;
            skip    <= '0;
            sr      <= '0;
         end else if (accept) begin
            sr      <= window[PAT_LEN-2:0];
            bit_idx <= bit_idx + 1'b1;
            if (state == IDLE) begin
               pat_q <= pattern;
               ovl_q <= overlap_en;
            end
            if (counted) begin
               acc <= acc_inc;
               if (!ovl_q) skip <= SKIP_LD;
            end else if (state == SCAN && skip != '0) begin
               skip <= skip - 1'b1;
            end
            // Final bit: publish including this bit's match, restart.
            if (state == SCAN && last) begin
               count       <= counted ? acc_inc : acc;
               count_valid <= 1'b1;
               bit_idx     <= '0;
               acc         <= '0;
               skip        <= '0;
               sr          <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_pattern_counter_stream.sv
// tb_pattern_counter_stream: randomized and directed frames checked
// against a frame-level match-counting model.
module tb_pattern_counter_stream;
   localparam int FL = 20;
   localparam int PL = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [PL-1:0] pattern = '0;
   logic          overlap_en = 1'b0;
   logic          bit_in = 1'b0;
   logic          bit_valid = 1'b0;
   logic          frame_clr = 1'b0;
   logic          hit, count_valid, busy;
   logic          hit_s, count_valid_s, busy_s;
   logic [4:0]    count;
   logic [2:0]    count_s;

   int tests_run = 0;
   int fails = 0;
   int cyc = 0;
   int hits_seen = 0;
   int hits_s_seen = 0;
   int cv_s_seen = 0;
   int cv_cnt_q[$];
   int cv_cnt_s_q[$];
   int cv_cyc_q[$];

   pattern_counter_stream #(.FRAME_LEN(FL), .PAT_LEN(PL), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .pattern(pattern),
      .overlap_en(overlap_en), .bit_in(bit_in),
      .bit_valid(bit_valid), .frame_clr(frame_clr),
      .hit(hit), .count(count), .count_valid(count_valid),
      .busy(busy)
   );

   pattern_counter_stream #(.FRAME_LEN(FL), .PAT_LEN(PL), .CNT_W(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .pattern(pattern),
      .overlap_en(overlap_en), .bit_in(bit_in),
      .bit_valid(bit_valid), .frame_clr(frame_clr),
      .hit(hit_s), .count(count_s), .count_valid(count_valid_s),
      .busy(busy_s)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (hit) hits_seen++;
      if (hit_s) hits_s_seen++;
      if (count_valid_s) cv_s_seen++;
      if (count_valid) begin
         cv_cnt_q.push_back(int'(count));
         cv_cnt_s_q.push_back(int'(count_s));
         cv_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // fr[i] is the i-th bit sent; window's earliest bit meets p[PL-1].
   function automatic int model_raw(input logic [FL-1:0] fr,
                                    input logic [PL-1:0] p,
                                    input logic o);
      int n;
      int next_ok;
      logic [PL-1:0] w;
      n = 0;
      next_ok = 0;
      for (int e = PL - 1; e < FL; e++) begin
         for (int k = 0; k < PL; k++) w[PL-1-k] = fr[e-PL+1+k];
         if (w == p && (o || e >= next_ok)) begin
            n++;
            next_ok = e + PL;
         end
      end
      return n;
   endfunction

   function automatic int sat(input int v, input int w);
      return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
   endfunction

   function automatic logic [FL-1:0] gen_frame(input logic [PL-1:0] p);
      logic [FL-1:0] f;
      for (int i = 0; i < FL; i++)
         f[i] = p[PL-1-(i%PL)] ^ ($urandom_range(4, 0) == 0);
      return f;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bit_valid = 1'b0;
         frame_clr = 1'b0;
      end
   endtask

   task automatic send_bits(input logic [FL-1:0] fr, input int nb,
                            input logic [PL-1:0] p, input logic o,
                            input int maxgap, input int alt_at,
                            output int lc);
      lc = 0;
      for (int i = 0; i < nb; i++) begin
         int g;
         g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         repeat (g) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_in = 1'($urandom);
         end
         @(negedge clk);
         bit_valid = 1'b1;
         frame_clr = 1'b0;
         bit_in = fr[i];
         if (alt_at >= 0 && i >= alt_at) begin
            pattern = ~p;
            overlap_en = ~o;
         end else begin
            pattern = p;
            overlap_en = o;
         end
         lc = cyc;
      end
   endtask

   task automatic obs_frame(input logic [FL-1:0] fr,
                            input logic [PL-1:0] p, input logic o,
                            input int maxgap, input int alt_at,
                            output int n_cv, output int cnt,
                            output int cnt_s, output int nh,
                            output int lat);
      int q0, h0, lc;
      q0 = cv_cnt_q.size();
      h0 = hits_seen;
      send_bits(fr, FL, p, o, maxgap, alt_at, lc);
      idle(3);
      n_cv = cv_cnt_q.size() - q0;
      nh = hits_seen - h0;
      cnt = -1;
      cnt_s = -1;
      lat = -1;
      if (n_cv > 0) begin
         cnt = cv_cnt_q[q0];
         cnt_s = cv_cnt_s_q[q0];
         lat = cv_cyc_q[q0] - lc;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (hit !== 1'b0) begin
         fails++; $display("FAIL reset_hit got=%0b exp=0", hit);
      end
      tests_run++;
      if (count !== 5'd0 || count_s !== 3'd0) begin
         fails++; $display("FAIL reset_count got=%0d/%0d exp=0", count, count_s);
      end
      tests_run++;
      if (count_valid !== 1'b0) begin
         fails++; $display("FAIL reset_cv got=%0b exp=0", count_valid);
      end
      tests_run++;
      if (busy !== 1'b0 || busy_s !== 1'b0) begin
         fails++; $display("FAIL reset_busy got=%0b exp=0", busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_overlap();
      int n_cv, cnt, cnt_s, nh, lat, e;
      e = model_raw(20'h55555, 4'b1010, 1'b1);
      obs_frame(20'h55555, 4'b1010, 1'b1, 0, -1, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (n_cv != 1) begin
         fails++; $display("FAIL ovl_cv_pulses got=%0d exp=1", n_cv);
      end
      tests_run++;
      if (cnt != 9 || cnt != sat(e, 5)) begin
         fails++; $display("FAIL ovl_count got=%0d exp=9", cnt);
      end
      tests_run++;
      if (nh != 9) begin
         fails++; $display("FAIL ovl_hits got=%0d exp=9", nh);
      end
      tests_run++;
      if (cnt_s != sat(e, 3)) begin
         fails++; $display("FAIL ovl_count_w3 got=%0d exp=%0d", cnt_s, sat(e, 3));
      end
      tests_run++;
      if (lat != 1) begin
         fails++; $display("FAIL ovl_latency got=%0d exp=1", lat);
      end
   endtask

   task automatic test_nonoverlap();
      int n_cv, cnt, cnt_s, nh, lat;
      obs_frame(20'h55555, 4'b1010, 1'b0, 0, -1, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (cnt != 5 || nh != model_raw(20'h55555, 4'b1010, 1'b0)) begin
         fails++; $display("FAIL novl_count got=%0d hits=%0d exp=5", cnt, nh);
      end
      obs_frame(20'h0, 4'b0000, 1'b1, 0, -1, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (cnt != 17 || nh != 17) begin
         fails++; $display("FAIL zero_ovl got=%0d hits=%0d exp=17", cnt, nh);
      end
      obs_frame(20'h0, 4'b0000, 1'b0, 0, -1, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (cnt != 5 || cnt_s != 5) begin
         fails++; $display("FAIL zero_novl got=%0d/%0d exp=5", cnt, cnt_s);
      end
   endtask

   task automatic test_gaps();
      int n_cv, cnt, cnt_s, nh, lat;
      for (int r = 0; r < 3; r++) begin
         obs_frame(20'h55555, 4'b1010, 1'b1, 3, -1, n_cv, cnt, cnt_s, nh, lat);
         tests_run++;
         if (n_cv != 1 || cnt != 9 || lat != 1) begin
            fails++;
            $display("FAIL gaps_%0d cv=%0d count=%0d lat=%0d exp 1/9/1", r, n_cv, cnt, lat);
         end
      end
   endtask

   task automatic test_frame_clr();
      int q0, lc, n_cv, cnt, cnt_s, nh, lat, e;
      logic [FL-1:0] fr;
      q0 = cv_cnt_q.size();
      send_bits(20'h55555, 10, 4'b1010, 1'b1, 0, -1, lc);
      @(negedge clk);
      bit_valid = 1'b0;
      frame_clr = 1'b1;
      tests_run++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL clr_busy_before got=%0b exp=1", busy);
      end
      @(negedge clk);
      frame_clr = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || hit !== 1'b0 || count_valid !== 1'b0) begin
         fails++;
         $display("FAIL clr_after busy=%0b hit=%0b cv=%0b exp 0", busy, hit, count_valid);
      end
      obs_frame(20'h55555, 4'b1010, 1'b1, 0, -1, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (cv_cnt_q.size() - q0 != 1 || cnt != 9) begin
         fails++;
         $display("FAIL clr_frame pulses=%0d count=%0d exp 1/9", cv_cnt_q.size() - q0, cnt);
      end
      q0 = cv_cnt_q.size();
      send_bits(20'hAAAAA, 5, 4'b0110, 1'b1, 0, -1, lc);
      @(negedge clk);
      bit_valid = 1'b1;
      frame_clr = 1'b1;
      bit_in = 1'b1;
      fr = gen_frame(4'b0110);
      e = model_raw(fr, 4'b0110, 1'b1);
      obs_frame(fr, 4'b0110, 1'b1, 1, -1, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (cv_cnt_q.size() - q0 != 1 || lat != 1 || cnt != e) begin
         fails++;
         $display("FAIL clr_drop pulses=%0d lat=%0d count=%0d exp 1/1/%0d",
                  cv_cnt_q.size() - q0, lat, cnt, e);
      end
   endtask

   task automatic test_shadow();
      int n_cv, cnt, cnt_s, nh, lat;
      obs_frame(20'h55555, 4'b1010, 1'b0, 2, 8, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (cnt != 5) begin
         fails++; $display("FAIL shadow_novl got=%0d exp=5", cnt);
      end
      obs_frame(20'h55555, 4'b1010, 1'b1, 2, 8, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (cnt != 9 || nh != 9) begin
         fails++; $display("FAIL shadow_ovl got=%0d hits=%0d exp=9", cnt, nh);
      end
   endtask

   task automatic test_reset_mid();
      int q0, lc, n_cv, cnt, cnt_s, nh, lat;
      send_bits(20'h55555, 12, 4'b1010, 1'b1, 0, -1, lc);
      @(negedge clk);
      bit_valid = 1'b0;
      q0 = cv_cnt_q.size();
      tests_run++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL midrst_busy_before got=%0b exp=1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (hit !== 1'b0 || count !== 5'd0 || count_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL midrst_outputs hit=%0b count=%0d cv=%0b busy=%0b exp 0",
                  hit, count, count_valid, busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      tests_run++;
      if (cv_cnt_q.size() != q0) begin
         fails++; $display("FAIL midrst_no_cv got=%0d exp=0", cv_cnt_q.size() - q0);
      end
      obs_frame(20'h55555, 4'b1010, 1'b1, 1, -1, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (n_cv != 1 || cnt != 9) begin
         fails++; $display("FAIL midrst_next cv=%0d count=%0d exp 1/9", n_cv, cnt);
      end
   endtask

   task automatic test_saturation();
      int n_cv, cnt, cnt_s, nh, lat;
      obs_frame(20'h0, 4'b0000, 1'b1, 2, -1, n_cv, cnt, cnt_s, nh, lat);
      tests_run++;
      if (cnt_s != 7) begin
         fails++; $display("FAIL sat_w3 got=%0d exp=7", cnt_s);
      end
      tests_run++;
      if (cnt != 17 || nh != 17) begin
         fails++; $display("FAIL sat_w5 got=%0d hits=%0d exp=17", cnt, nh);
      end
   endtask

   task automatic test_back_to_back();
      int q0, lc1, lc2, e1, e2;
      logic [FL-1:0] f1, f2;
      logic [PL-1:0] p;
      p = 4'b1101;
      f1 = gen_frame(p);
      f2 = gen_frame(p);
      e1 = model_raw(f1, p, 1'b1);
      e2 = model_raw(f2, p, 1'b1);
      q0 = cv_cnt_q.size();
      send_bits(f1, FL, p, 1'b1, 0, -1, lc1);
      send_bits(f2, FL, p, 1'b1, 0, -1, lc2);
      idle(3);
      tests_run++;
      if (cv_cnt_q.size() - q0 != 2) begin
         fails++; $display("FAIL b2b_pulses got=%0d exp=2", cv_cnt_q.size() - q0);
      end else begin
         tests_run++;
         if (cv_cyc_q[q0+1] - cv_cyc_q[q0] != 20) begin
            fails++;
            $display("FAIL b2b_spacing got=%0d exp=20", cv_cyc_q[q0+1] - cv_cyc_q[q0]);
         end
         tests_run++;
         if (cv_cnt_q[q0] != sat(e1, 5) || cv_cnt_q[q0+1] != sat(e2, 5)) begin
            fails++;
            $display("FAIL b2b_counts got=%0d,%0d exp=%0d,%0d",
                     cv_cnt_q[q0], cv_cnt_q[q0+1], sat(e1, 5), sat(e2, 5));
         end
      end
   endtask

   task automatic test_random();
      int n_cv, cnt, cnt_s, nh, lat, e, hs0, cs0;
      logic [FL-1:0] fr;
      logic [PL-1:0] p;
      logic o;
      for (int r = 0; r < 12; r++) begin
         p = PL'($urandom);
         o = 1'($urandom);
         fr = gen_frame(p);
         e = model_raw(fr, p, o);
         hs0 = hits_s_seen;
         cs0 = cv_s_seen;
         obs_frame(fr, p, o, 3, -1, n_cv, cnt, cnt_s, nh, lat);
         tests_run++;
         if (n_cv != 1 || cnt != sat(e, 5) || nh != e || lat != 1) begin
            fails++;
            $display("FAIL rand_%0d cv=%0d count=%0d hits=%0d lat=%0d exp 1/%0d/%0d/1",
                     r, n_cv, cnt, nh, lat, sat(e, 5), e);
         end
         tests_run++;
         if (cnt_s != sat(e, 3) || hits_s_seen - hs0 != e || cv_s_seen - cs0 != 1) begin
            fails++;
            $display("FAIL rand_w3_%0d count=%0d exp=%0d", r, cnt_s, sat(e, 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_gaps();
      test_frame_clr();
      test_shadow();
      test_reset_mid();
      test_saturation();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
